// File: rtl/wb_grf.sv
// rtl/wb_grf.sv - general register file with write-back bypass and pending-write scoreboard
module wb_grf #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite_WD,
    input  logic [ADDR_W-1:0] WRegAdd_D,
    input  logic [DATA_W-1:0] result_WD,
    input  logic [ADDR_W-1:0] RAdd1_D,
    input  logic [ADDR_W-1:0] RAdd2_D,
    input  logic              Use1_D,
    input  logic              Use2_D,
    input  logic              issue_D,
    input  logic [ADDR_W-1:0] IRegAdd_D,
    output logic [DATA_W-1:0] RData1_D,
    output logic [DATA_W-1:0] RData2_D,
    output logic              stall_D,
    output logic              busy_D,
    output logic              err_D
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  cnt  [NREG];
    logic [NREG-1:0]   dec;
    logic [NREG-1:0]   inc;
    logic [NREG-1:0]   nz;
    logic              pend1, pend2, full, err_q;

    // dec is also the bypass select, so it carries the reset gate and the r0 exclusion
    always_comb begin
        dec = '0;
        nz  = '0;
        for (int i = 1; i < NREG; i++) begin
            dec[i] = reset && RegWrite_WD && (WRegAdd_D == ADDR_W'(i));
            nz[i]  = (cnt[i] != '0);
        end
    end

    always_comb begin
        inc = '0;
        for (int i = 1; i < NREG; i++) begin
            inc[i] = reset && issue_D && !stall_D && (IRegAdd_D == ADDR_W'(i));
        end
    end

    // An operand is clear when its last outstanding write-back lands this cycle
    assign pend1 = (RAdd1_D != '0) && (cnt[RAdd1_D] != '0)
                && !((cnt[RAdd1_D] == CNT_ONE) && dec[RAdd1_D]);
    assign pend2 = (RAdd2_D != '0) && (cnt[RAdd2_D] != '0)
                && !((cnt[RAdd2_D] == CNT_ONE) && dec[RAdd2_D]);
    assign full  = issue_D && (IRegAdd_D != '0) && (cnt[IRegAdd_D] == CNT_MAX)
                && !dec[IRegAdd_D];

    assign stall_D  = reset && ((Use1_D && pend1) || (Use2_D && pend2) || full);
    assign busy_D   = |nz;
    assign err_D    = err_q;
    assign RData1_D = dec[RAdd1_D] ? result_WD : regs[RAdd1_D];
    assign RData2_D = dec[RAdd2_D] ? result_WD : regs[RAdd2_D];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (RegWrite_WD && (WRegAdd_D != '0)) begin
            regs[WRegAdd_D] <= result_WD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (inc[i] && !dec[i]) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end else if (dec[i]) begin
                    // a write-back with nothing outstanding is a pipeline bookkeeping error
                    if (cnt[i] == '0) begin
                        cnt[i] <= inc[i] ? CNT_ONE : '0;
                        err_q  <= 1'b1;
                    end else if (!inc[i]) begin
                        cnt[i] <= cnt[i] - CNT_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_grf.sv
// tb/tb_wb_grf.sv - directed scoreboard bench for wb_grf
module tb_wb_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_WD;
    logic [4:0]  WRegAdd_D;
    logic [31:0] result_WD;
    logic [4:0]  RAdd1_D, RAdd2_D;
    logic        Use1_D, Use2_D;
    logic        issue_D;
    logic [4:0]  IRegAdd_D;
    logic [31:0] RData1_D, RData2_D;
    logic        stall_D, busy_D, err_D;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];

    localparam int S_RD1 = 0, S_RD2 = 1, S_STALL = 2, S_BUSY = 3, S_ERR = 4;

    wb_grf dut (
        .clk(clk), .reset(reset),
        .RegWrite_WD(RegWrite_WD), .WRegAdd_D(WRegAdd_D), .result_WD(result_WD),
        .RAdd1_D(RAdd1_D), .RAdd2_D(RAdd2_D), .Use1_D(Use1_D), .Use2_D(Use2_D),
        .issue_D(issue_D), .IRegAdd_D(IRegAdd_D),
        .RData1_D(RData1_D), .RData2_D(RData2_D),
        .stall_D(stall_D), .busy_D(busy_D), .err_D(err_D)
    );

    always #5 clk = ~clk;

    task automatic expect_v(input int sig, input logic [31:0] val, input string tag);
        exp_t e;
        e.sig = sig;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sig)
                S_RD1:   obs = RData1_D;
                S_RD2:   obs = RData2_D;
                S_STALL: obs = {31'b0, stall_D};
                S_BUSY:  obs = {31'b0, busy_D};
                default: obs = {31'b0, err_D};
            endcase
            checks++;
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b0; RegWrite_WD = 1'b0; WRegAdd_D = '0; result_WD = '0;
        RAdd1_D = '0; RAdd2_D = '0; Use1_D = 1'b0; Use2_D = 1'b0;
        issue_D = 1'b0; IRegAdd_D = '0;
        tick(); tick();

        // writes and issues ignored while in reset
        RegWrite_WD = 1'b1; WRegAdd_D = 5'd5; result_WD = 32'h1234;
        RAdd1_D = 5'd5; RAdd2_D = 5'd5; Use1_D = 1'b1; issue_D = 1'b1; IRegAdd_D = 5'd5;
        expect_v(S_RD1, 32'h0, "rst_rd1"); expect_v(S_RD2, 32'h0, "rst_rd2");
        expect_v(S_STALL, 0, "rst_stall"); expect_v(S_BUSY, 0, "rst_busy");
        expect_v(S_ERR, 0, "rst_err");
        check_all();
        tick();
        RegWrite_WD = 1'b0; issue_D = 1'b0; Use1_D = 1'b0; reset = 1'b1;
        expect_v(S_RD1, 32'h0, "rst_r5_kept0"); expect_v(S_BUSY, 0, "rst_busy_after");
        check_all();
        tick();

        // write r8 with bypass, then from storage
        issue_D = 1'b1; IRegAdd_D = 5'd8;
        expect_v(S_STALL, 0, "iss8_stall");
        check_all();
        tick();
        issue_D = 1'b0; RegWrite_WD = 1'b1; WRegAdd_D = 5'd8; result_WD = 32'hDEADBEEF;
        RAdd1_D = 5'd8; Use1_D = 1'b1;
        expect_v(S_RD1, 32'hDEADBEEF, "byp_r8"); expect_v(S_STALL, 0, "byp_r8_stall");
        expect_v(S_BUSY, 1, "byp_r8_busy");
        check_all();
        tick();
        RegWrite_WD = 1'b0;
        expect_v(S_RD1, 32'hDEADBEEF, "stor_r8"); expect_v(S_BUSY, 0, "r8_busy0");
        expect_v(S_ERR, 0, "r8_err0");
        check_all();
        RegWrite_WD = 1'b1; WRegAdd_D = 5'd0; result_WD = 32'hFFFFFFFF; RAdd2_D = 5'd0;
        Use1_D = 1'b0;
        expect_v(S_RD2, 32'h0, "r0_byp");
        check_all();
        tick();
        RegWrite_WD = 1'b0;
        expect_v(S_RD2, 32'h0, "r0_stor"); expect_v(S_ERR, 0, "r0_err0");
        check_all();

        // RAW hazard on r3 cleared by its write-back
        issue_D = 1'b1; IRegAdd_D = 5'd3;
        tick();
        issue_D = 1'b0; Use1_D = 1'b1; RAdd1_D = 5'd3;
        expect_v(S_STALL, 1, "r3_stall"); expect_v(S_BUSY, 1, "r3_busy");
        check_all();
        tick();
        RegWrite_WD = 1'b1; WRegAdd_D = 5'd3; result_WD = 32'h77;
        expect_v(S_STALL, 0, "r3_wb_stall"); expect_v(S_RD1, 32'h77, "r3_wb_rd");
        check_all();
        tick();
        RegWrite_WD = 1'b0; Use1_D = 1'b0;
        expect_v(S_BUSY, 0, "r3_busy0"); expect_v(S_RD1, 32'h77, "r3_stor");
        check_all();

        // counter saturation on r9
        issue_D = 1'b1; IRegAdd_D = 5'd9;
        for (int k = 0; k < 3; k++) begin
            expect_v(S_STALL, 0, $sformatf("r9_iss%0d", k));
            check_all();
            tick();
        end
        expect_v(S_STALL, 1, "r9_full"); expect_v(S_BUSY, 1, "r9_busy");
        check_all();
        tick();
        expect_v(S_STALL, 1, "r9_full_hold");
        check_all();
        RegWrite_WD = 1'b1; WRegAdd_D = 5'd9; result_WD = 32'h99;
        expect_v(S_STALL, 0, "r9_full_wb");
        check_all();
        tick();
        RegWrite_WD = 1'b0;
        expect_v(S_STALL, 1, "r9_still3");
        check_all();
        issue_D = 1'b0; RegWrite_WD = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        RegWrite_WD = 1'b0;
        expect_v(S_BUSY, 0, "r9_drained"); expect_v(S_ERR, 0, "r9_err0");
        check_all();

        // underflow on r12 is sticky
        RegWrite_WD = 1'b1; WRegAdd_D = 5'd12; result_WD = 32'h5;
        expect_v(S_ERR, 0, "r12_err_same");
        check_all();
        tick();
        RegWrite_WD = 1'b0;
        expect_v(S_ERR, 1, "r12_err_set");
        check_all();
        tick(); tick();
        expect_v(S_ERR, 1, "r12_err_sticky");
        check_all();

        // asynchronous reset mid-cycle
        issue_D = 1'b1; IRegAdd_D = 5'd4;
        tick();
        issue_D = 1'b0; Use1_D = 1'b1; RAdd1_D = 5'd4;
        expect_v(S_STALL, 1, "r4_stall"); expect_v(S_BUSY, 1, "r4_busy");
        check_all();
        #1 reset = 1'b0;
        expect_v(S_STALL, 0, "async_stall"); expect_v(S_BUSY, 0, "async_busy");
        expect_v(S_ERR, 0, "async_err");
        check_all();
        #1 reset = 1'b1;
        tick();
        Use1_D = 1'b0; RAdd1_D = 5'd8;
        expect_v(S_RD1, 32'h0, "r8_cleared");
        check_all();
        RegWrite_WD = 1'b1; WRegAdd_D = 5'd4; result_WD = 32'h1;
        tick();
        RegWrite_WD = 1'b0;
        expect_v(S_ERR, 1, "r4_stale_wb_err");
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
